// File: rtl/ram_pkg.sv
// Shared definitions for the burst RAM port master and the 32x4 RAM wrapper.
package ram_pkg;

    localparam int AW    = 5;
    localparam int DW    = 4;
    localparam int DEPTH = 32;

    // Burst engine states: IDLE accepts commands, WRITE fills, READ issues
    // addresses, DRAIN waits for the read pipeline and FIFO to empty.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry FIFO holding read beats (data plus last flag) between the RAM
// read port and the downstream ready/valid stream.
module rd_skid_fifo
    import ram_pkg::*;
#(
    parameter int W = ram_pkg::DW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count,
    output logic         not_empty
);

    logic [W-1:0] mem_q [2];
    logic         wr_q;
    logic         rd_q;
    logic [1:0]   count_q;
    logic         do_push;
    logic         do_pop;

    // A push into a full FIFO is only taken when a pop frees a slot the same cycle.
    always_comb begin
        do_pop  = pop && (count_q != 2'd0);
        do_push = push && ((count_q != 2'd2) || do_pop);
    end

    // Storage, pointers and occupancy; simultaneous push and pop keeps count.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= push_data;
                wr_q        <= ~wr_q;
            end
            if (do_pop) begin
                rd_q <= ~rd_q;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head      = mem_q[rd_q];
    assign count     = count_q;
    assign not_empty = (count_q != 2'd0);

endmodule

// File: rtl/ram_port_master.sv
// Burst command engine driving one port of the 32x4 dual-port RAM.
// Write commands fill len+1 consecutive words with one value; read commands
// stream len+1 consecutive words out through a two-entry FIFO with
// ready/valid flow control. Addresses wrap modulo 2^AW.
module ram_port_master #(
    parameter int AW = ram_pkg::AW,
    parameter int DW = ram_pkg::DW
) (
    input  logic          clk1,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [AW-1:0] cmd_len,
    input  logic [DW-1:0] cmd_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          rd_last,
    output logic          busy,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_di,
    input  logic [DW-1:0] ram_do
);

    import ram_pkg::*;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    // Length and beat counter carry one extra bit so len=31 gives 32 beats.
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   beat_q, beat_d;
    logic [DW-1:0] data_q, data_d;
    // A read issued last cycle: its word is on ram_do now and gets pushed.
    logic          inflight_q, inflight_d;
    logic          last_pend_q, last_pend_d;

    logic [1:0]    fifo_count;
    logic          fifo_not_empty;
    logic [DW:0]   fifo_head;
    logic          pop;
    logic          issue;
    logic          final_beat;

    // Next-state, address/beat advance and read-issue throttling.
    always_comb begin
        pop        = fifo_not_empty && rd_ready;
        final_beat = (beat_q == len_q);
        // Issue only while the FIFO is guaranteed room for the word one cycle later.
        issue      = (state_q == READ) &&
                     (({1'b0, fifo_count} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        beat_d      = beat_q;
        data_d      = data_q;
        inflight_d  = issue;
        last_pend_d = issue && final_beat;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    len_d   = {1'b0, cmd_len};
                    data_d  = cmd_data;
                    beat_d  = '0;
                    state_d = cmd_write ? WRITE : READ;
                end
            end
            WRITE: begin
                addr_d = addr_q + AW'(1);
                beat_d = beat_q + (AW + 1)'(1);
                if (final_beat) begin
                    state_d = IDLE;
                end
            end
            READ: begin
                if (issue) begin
                    addr_d = addr_q + AW'(1);
                    beat_d = beat_q + (AW + 1)'(1);
                    if (final_beat) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if ((fifo_count == 2'd0) && !inflight_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and datapath registers; reset wins over every other input.
    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            data_q      <= '0;
            inflight_q  <= 1'b0;
            last_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            data_q      <= data_d;
            inflight_q  <= inflight_d;
            last_pend_q <= last_pend_d;
        end
    end

    rd_skid_fifo #(
        .W (DW + 1)
    ) u_fifo (
        .clk       (clk1),
        .rst       (rst),
        .push      (inflight_q),
        .push_data ({ram_do, last_pend_q}),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .not_empty (fifo_not_empty)
    );

    // Output decode: all outputs come straight from registers.
    always_comb begin
        cmd_ready = (state_q == IDLE);
        busy      = (state_q != IDLE);
        ram_we    = (state_q == WRITE);
        ram_addr  = addr_q;
        ram_di    = data_q;
        rd_valid  = fifo_not_empty;
        rd_data   = fifo_head[DW:1];
        rd_last   = fifo_head[0];
    end

endmodule
